// File: rtl/dp_booth4.sv
// Radix-4 Booth multiplier datapath: operand/accumulator/shift/counter registers
// driven by a 9-bit control word, with scan status returned to the control unit.
module dp_booth4 #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [8:0]   c,
  input  logic [N-1:0] inbus,
  output logic [N-1:0] outbus,
  output logic         out_valid,
  output logic         count,
  output logic         q0,
  output logic         q1,
  output logic         qm
);
  localparam int CW = (N / 2 > 1) ? $clog2(N / 2) : 1;
  localparam int AW = N + 2;

  if (N < 4 || (N % 2) != 0) begin : g_bad_n
    $error("dp_booth4: N must be even and >= 4");
  end

  logic [N-1:0]  m_r;
  logic [AW-1:0] a_r;
  logic [N-1:0]  q_r;
  logic          qm_r;
  logic [CW-1:0] cnt_r;

  logic [AW-1:0] d, sum;

  // Two guard bits keep +/-2M in range even for M = -2^(N-1).
  always_comb begin
    d   = c[4] ? {m_r[N-1], m_r, 1'b0} : {{2{m_r[N-1]}}, m_r};
    sum = c[3] ? (a_r - d) : (a_r + d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_r       <= '0;
      a_r       <= '0;
      q_r       <= '0;
      qm_r      <= 1'b0;
      cnt_r     <= '0;
      outbus    <= '0;
      out_valid <= 1'b0;
    end else begin
      if (c[0]) m_r <= inbus;

      if (c[1]) begin
        q_r  <= inbus;
        a_r  <= '0;
        qm_r <= 1'b0;
      end else if (c[2]) begin
        a_r <= sum;
      end else if (c[5]) begin
        {a_r, q_r, qm_r} <= {a_r[AW-1], a_r, q_r};
      end

      if (c[1])      cnt_r <= '0;
      else if (c[6]) cnt_r <= cnt_r + CW'(1);

      if (c[7]) begin
        outbus    <= a_r[N-1:0];
        out_valid <= 1'b1;
      end else if (c[8]) begin
        outbus    <= q_r;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  assign count = (cnt_r == CW'(N / 2 - 1));
  assign q0    = q_r[0];
  assign q1    = q_r[1];
  assign qm    = qm_r;

endmodule

// File: tb/tb_dp_booth4.sv
// Directed bench for dp_booth4: emulates the Booth control unit over a vector
// table, plus hand sequences for priority, sign extension and async reset.
module tb_dp_booth4;
  localparam int N = 8;

  localparam logic [8:0] LD_M  = 9'h001;
  localparam logic [8:0] LD_Q  = 9'h002;
  localparam logic [8:0] ADD   = 9'h004;
  localparam logic [8:0] SUB   = 9'h008;
  localparam logic [8:0] X2    = 9'h010;
  localparam logic [8:0] SHR   = 9'h020;
  localparam logic [8:0] INC   = 9'h040;
  localparam logic [8:0] OUT_A = 9'h080;
  localparam logic [8:0] OUT_Q = 9'h100;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [8:0]   c;
  logic [N-1:0] inbus;
  logic [N-1:0] outbus;
  logic         out_valid, count, q0, q1, qm;

  int checks = 0;
  int passed = 0;

  dp_booth4 #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .c(c), .inbus(inbus), .outbus(outbus),
    .out_valid(out_valid), .count(count), .q0(q0), .q1(q1), .qm(qm)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] m;
    logic [N-1:0] q;
    logic [N-1:0] hi;
    logic [N-1:0] lo;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic cyc(input logic [8:0] cw, input logic [N-1:0] ib);
    c = cw;
    inbus = ib;
    @(posedge clk);
    #1;
    c = '0;
  endtask

  // Plays the control-unit sequence and checks status and both result words.
  task automatic run_mult(input string tag, input logic [N-1:0] mv, input logic [N-1:0] qv,
                          input logic [N-1:0] hi, input logic [N-1:0] lo);
    logic [N:0]   qx;
    logic [2:0]   trip;
    logic [8:0]   op;
    bit           done;
    qx = {qv, 1'b0};
    done = 0;
    cyc(LD_M, mv);
    cyc(LD_Q, qv);
    for (int it = 0; it < N / 2 + 2 && !done; it++) begin
      trip = {q1, q0, qm};
      if (it < N / 2) chk({tag, " triplet"}, 32'(trip), 32'(qx[2*it+2 -: 3]));
      case (trip)
        3'b001, 3'b010: op = ADD;
        3'b011:         op = ADD | X2;
        3'b100:         op = ADD | SUB | X2;
        3'b101, 3'b110: op = ADD | SUB;
        default:        op = '0;
      endcase
      if (op != '0) cyc(op, '0);
      cyc(SHR, '0);
      cyc(SHR, '0);
      chk({tag, " count"}, 32'(count), 32'(it == N / 2 - 1));
      if (count) done = 1;
      else cyc(INC, '0);
    end
    if (!done) chk({tag, " iteration bound"}, 32'(0), 32'(1));
    cyc(OUT_A, '0);
    chk({tag, " hi valid"}, 32'(out_valid), 32'(1));
    chk({tag, " hi"}, 32'(outbus), 32'(hi));
    cyc(OUT_Q, '0);
    chk({tag, " lo valid"}, 32'(out_valid), 32'(1));
    chk({tag, " lo"}, 32'(outbus), 32'(lo));
    cyc('0, '0);
    chk({tag, " idle valid"}, 32'(out_valid), 32'(0));
    chk({tag, " idle hold"}, 32'(outbus), 32'(lo));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h07, 8'h03, 8'h00, 8'h15};  // 7 * 3 = 21
    vecs[1] = '{8'hFB, 8'h06, 8'hFF, 8'hE2};  // -5 * 6 = -30
    vecs[2] = '{8'h80, 8'h80, 8'h40, 8'h00};  // -128 * -128 = 16384
    vecs[3] = '{8'h7F, 8'h80, 8'hC0, 8'h80};  // 127 * -128 = -16256
    vecs[4] = '{8'h80, 8'h7F, 8'hC0, 8'h80};  // -128 * 127
    vecs[5] = '{8'h7F, 8'h7F, 8'h3F, 8'h01};  // 127 * 127 = 16129
    vecs[6] = '{8'hFF, 8'hFF, 8'h00, 8'h01};  // -1 * -1 = 1

    rst_n = 1'b0;
    c = '0;
    inbus = '0;
    #1;
    chk("reset outbus", 32'(outbus), 0);
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset count", 32'(count), 0);
    chk("reset status", 32'({q1, q0, qm}), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) run_mult($sformatf("vec%0d", i), vecs[i].m, vecs[i].q, vecs[i].hi, vecs[i].lo);

    // Subtract 2M from zero: A = -10 (0x3F6); shift it all into Q to expose the top bits.
    cyc(LD_M, 8'h05);
    cyc(LD_Q, 8'h00);
    cyc(ADD | SUB | X2, '0);
    cyc(OUT_A, '0);
    chk("sub2m A low", 32'(outbus), 32'h F6);
    for (int k = 0; k < N; k++) cyc(SHR, '0);
    cyc(OUT_A, '0);
    chk("sub2m A sign", 32'(outbus), 32'h FF);
    cyc(OUT_Q, '0);
    chk("sub2m shifted Q", 32'(outbus), 32'h F6);

    // Load beats shift on the same edge; c[7] beats c[8].
    cyc(LD_M, 8'h05);
    cyc(LD_Q, 8'hFF);
    cyc(ADD, '0);
    cyc(SHR, '0);
    chk("pre-load qm", 32'(qm), 1);
    cyc(LD_Q | SHR, 8'h3C);
    chk("load+shift status", 32'({q1, q0, qm}), 0);
    cyc(OUT_A | OUT_Q, '0);
    chk("load+shift A / out priority", 32'(outbus), 0);
    cyc(OUT_Q, '0);
    chk("load+shift Q", 32'(outbus), 32'h 3C);

    // Counter reaches N/2-1, then a load clears it despite a concurrent increment.
    cyc(INC, '0);
    cyc(INC, '0);
    cyc(INC, '0);
    chk("cnt at N/2-1", 32'(count), 1);
    cyc(INC, '0);
    chk("cnt wrap", 32'(count), 0);
    cyc(INC, '0);
    cyc(INC, '0);
    cyc(INC, '0);
    cyc(LD_Q | INC, 8'h01);
    chk("load beats inc", 32'(count), 0);

    // Async reset between edges mid-multiply (127 * 127 after its first pair).
    cyc(LD_M, 8'h7F);
    cyc(LD_Q, 8'h7F);
    cyc(ADD | SUB, '0);
    cyc(SHR, '0);
    cyc(SHR, '0);
    cyc(INC, '0);
    cyc(OUT_A, '0);
    chk("pre-reset outbus", 32'(outbus), 32'h E0);
    chk("pre-reset status", 32'({q1, q0, qm}), 32'b111);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset outbus", 32'(outbus), 0);
    chk("async reset out_valid", 32'(out_valid), 0);
    chk("async reset count", 32'(count), 0);
    chk("async reset status", 32'({q1, q0, qm}), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset held out_valid", 32'(out_valid), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_mult("post-reset", 8'h7F, 8'h7F, 8'h3F, 8'h01);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
